// File: rtl/tracer_scheduler_if.sv
// Bundles the frame-control, lane-pool and framebuffer-write signals of tracer_scheduler.
// master: the scheduler. slave: the frame controller, tracer lanes and framebuffer.
interface tracer_scheduler_if #(
  parameter int NUM_LANES = 4,
  parameter int COLOR_W   = 12
);
  logic                         frame_start;
  logic [127:0]                 in_bus;
  logic                         busy;
  logic                         frame_done;
  logic [127:0]                 scene_bus;
  logic [NUM_LANES-1:0]         lane_start;
  logic [6:0]                   lane_col;
  logic [5:0]                   lane_row;
  logic [NUM_LANES-1:0]         lane_done;
  logic [NUM_LANES*COLOR_W-1:0] lane_dout;
  logic                         wr_en;
  logic [6:0]                   col_addr;
  logic [5:0]                   row_addr;
  logic [COLOR_W-1:0]           dout;
  logic [23:0]                  frame_cycles;

  modport master (
    input  frame_start, in_bus, lane_done, lane_dout,
    output busy, frame_done, scene_bus, lane_start, lane_col, lane_row,
           wr_en, col_addr, row_addr, dout, frame_cycles
  );

  modport slave (
    output frame_start, in_bus, lane_done, lane_dout,
    input  busy, frame_done, scene_bus, lane_start, lane_col, lane_row,
           wr_en, col_addr, row_addr, dout, frame_cycles
  );
endinterface

// File: rtl/tracer_scheduler.sv
// Shares NUM_LANES ray-tracer lanes across a 128x64 frame and serialises their results.
// Optional frame cycle counter enabled by defining TRACER_SCHED_PERF_EN.
module tracer_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int COLOR_W   = 12
) (
  input logic                tracer_clk,
  input logic                rst,
  tracer_scheduler_if.master bus
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {L_FREE, L_BUSY, L_PEND} lane_t;

  state_t state_reg, state_next;

  lane_t              lane_state_reg [NUM_LANES];
  logic [6:0]         tag_col_reg    [NUM_LANES];
  logic [5:0]         tag_row_reg    [NUM_LANES];
  logic [COLOR_W-1:0] color_reg      [NUM_LANES];
  logic [COLOR_W-1:0] lane_color     [NUM_LANES];

  logic [127:0]         scene_reg;
  logic [6:0]           cnt_col_reg;
  logic [5:0]           cnt_row_reg;
  logic [LANE_W-1:0]    rr_reg;
  logic [NUM_LANES-1:0] lane_start_reg;
  logic [6:0]           lane_col_reg;
  logic [5:0]           lane_row_reg;
  logic                 wr_en_reg;
  logic [6:0]           col_addr_reg;
  logic [5:0]           row_addr_reg;
  logic [COLOR_W-1:0]   dout_reg;
  logic                 busy_reg;
  logic                 frame_done_reg;

  logic              accept;
  logic              any_free;
  logic              all_free;
  logic              disp_en;
  logic [LANE_W-1:0] disp_idx;
  logic              wr_sel_en;
  logic [LANE_W-1:0] wr_idx;
  logic              last_pixel;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_slice
      assign lane_color[gi] = bus.lane_dout[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  assign last_pixel = (cnt_col_reg == 7'd127) && (cnt_row_reg == 6'd63);

  always_ff @(posedge tracer_clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    any_free   = 1'b0;
    all_free   = 1'b1;
    disp_idx   = '0;
    wr_sel_en  = 1'b0;
    wr_idx     = '0;
    // Descending scan so the lowest-index FREE lane wins.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_state_reg[i] == L_FREE) begin
        any_free = 1'b1;
        disp_idx = LANE_W'(i);
      end else begin
        all_free = 1'b0;
      end
    end
    // Round-robin: the smallest offset from rr_reg wins, so scan offsets high to low.
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_reg) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (lane_state_reg[idx] == L_PEND) begin
        wr_sel_en = 1'b1;
        wr_idx    = LANE_W'(idx);
      end
    end
    disp_en = any_free && (state_reg == RUN);
    case (state_reg)
      IDLE: begin
        if (bus.frame_start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN:     if (disp_en && last_pixel) state_next = DRAIN;
      DRAIN:   if (all_free) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge tracer_clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_state_reg[i] <= L_FREE;
        tag_col_reg[i]    <= '0;
        tag_row_reg[i]    <= '0;
        color_reg[i]      <= '0;
      end
      scene_reg      <= '0;
      cnt_col_reg    <= '0;
      cnt_row_reg    <= '0;
      rr_reg         <= '0;
      lane_start_reg <= '0;
      lane_col_reg   <= '0;
      lane_row_reg   <= '0;
      wr_en_reg      <= 1'b0;
      col_addr_reg   <= '0;
      row_addr_reg   <= '0;
      dout_reg       <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      lane_start_reg <= '0;
      wr_en_reg      <= 1'b0;
      busy_reg       <= (state_next != IDLE);
      frame_done_reg <= (state_reg == DRAIN) && (state_next == DONE);
      if (accept) begin
        scene_reg   <= bus.in_bus;
        cnt_col_reg <= '0;
        cnt_row_reg <= '0;
      end
      // Completion, dispatch and write each touch lanes in a distinct state, so they never collide.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.lane_done[i] && lane_state_reg[i] == L_BUSY) begin
          lane_state_reg[i] <= L_PEND;
          color_reg[i]      <= lane_color[i];
        end
      end
      if (disp_en) begin
        lane_start_reg[disp_idx] <= 1'b1;
        lane_col_reg             <= cnt_col_reg;
        lane_row_reg             <= cnt_row_reg;
        lane_state_reg[disp_idx] <= L_BUSY;
        tag_col_reg[disp_idx]    <= cnt_col_reg;
        tag_row_reg[disp_idx]    <= cnt_row_reg;
        cnt_col_reg              <= cnt_col_reg + 7'd1;
        if (cnt_col_reg == 7'd127) cnt_row_reg <= cnt_row_reg + 6'd1;
      end
      if (wr_sel_en) begin
        wr_en_reg              <= 1'b1;
        col_addr_reg           <= tag_col_reg[wr_idx];
        row_addr_reg           <= tag_row_reg[wr_idx];
        dout_reg               <= color_reg[wr_idx];
        lane_state_reg[wr_idx] <= L_FREE;
        rr_reg <= (wr_idx == LANE_W'(NUM_LANES - 1)) ? '0 : wr_idx + 1'b1;
      end
    end
  end

`ifdef TRACER_SCHED_PERF_EN
  logic [23:0] perf_reg;

  always_ff @(posedge tracer_clk) begin
    if (!rst)                                 perf_reg <= '0;
    else if (accept)                          perf_reg <= '0;
    else if (busy_reg && perf_reg != '1)      perf_reg <= perf_reg + 24'd1;
  end

  assign bus.frame_cycles = perf_reg;
`else
  assign bus.frame_cycles = '0;
`endif

  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.scene_bus  = scene_reg;
  assign bus.lane_start = lane_start_reg;
  assign bus.lane_col   = lane_col_reg;
  assign bus.lane_row   = lane_row_reg;
  assign bus.wr_en      = wr_en_reg;
  assign bus.col_addr   = col_addr_reg;
  assign bus.row_addr   = row_addr_reg;
  assign bus.dout       = dout_reg;
endmodule

// File: tb/tb_tracer_scheduler.sv
// Self-checking bench for tracer_scheduler: directed timing cases plus a full frame
// with a fixed-latency lane model and a pixel/colour scoreboard.
`timescale 1ns/1ps
module tb_tracer_scheduler;
  localparam int NL     = 4;
  localparam int CW     = 12;
  localparam int LAT    = 5;
  localparam int NPIX   = 8192;
  localparam int BUDGET = 40000;

  typedef struct packed {
    logic [6:0]    c;
    logic [5:0]    r;
    logic [CW-1:0] color;
  } sb_t;

  logic tracer_clk = 1'b0;
  logic rst        = 1'b0;

  tracer_scheduler_if #(.NUM_LANES(NL), .COLOR_W(CW)) bus ();

  tracer_scheduler #(.NUM_LANES(NL), .COLOR_W(CW)) dut (
    .tracer_clk (tracer_clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 tracer_clk = ~tracer_clk;

  int total = 0;
  int bad   = 0;

  sb_t        sb [$];
  int         cnt [NL];
  logic [6:0] tc  [NL];
  logic [5:0] tr  [NL];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] pix_color(input logic [6:0] c, input logic [5:0] r);
    logic [15:0] t;
    t = {9'd0, c} * 16'd37 + {10'd0, r} * 16'd101 + 16'h05A3;
    return t[CW-1:0];
  endfunction

  task automatic tick();
    @(posedge tracer_clk);
    #1;
  endtask

  initial begin
    logic [127:0] scene_a, scene_b, scene_c;
    int wr_seen, ls_seen, disp_n, wr_n, done_n, done_cyc, cyc, extra, li, idx;
    logic [6:0] exp_c;
    logic [5:0] exp_r;

    scene_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    scene_b = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    scene_c = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1111_2222;
    bus.frame_start = 1'b0;
    bus.in_bus      = '0;
    bus.lane_done   = '0;
    bus.lane_dout   = '0;

    rst = 1'b0;
    repeat (3) tick();
    $display("reset applied");
    chk("rst_busy",         bus.busy,         0);
    chk("rst_lane_start",   bus.lane_start,   0);
    chk("rst_wr_en",        bus.wr_en,        0);
    chk("rst_frame_done",   bus.frame_done,   0);
    chk("rst_scene",        bus.scene_bus,    0);
    chk("rst_frame_cycles", bus.frame_cycles, 0);
    rst = 1'b1;
    tick();

    // Dispatch timing with all lanes free; lanes never complete here.
    bus.in_bus = scene_a;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.in_bus = scene_b;
    $display("frame_start accepted, scene=%0h", scene_a);
    chk("start_busy",  bus.busy,       1);
    chk("start_scene", bus.scene_bus,  scene_a);
    chk("start_ls0",   bus.lane_start, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("dispatch cycle %0d: lane_start=%b col=%0d row=%0d", k + 1, bus.lane_start, bus.lane_col, bus.lane_row);
      chk("disp_onehot", bus.lane_start, (k < 4) ? (1 << k) : 0);
      if (k < 4) begin
        chk("disp_col", bus.lane_col, k);
        chk("disp_row", bus.lane_row, 0);
      end
    end

    bus.in_bus = scene_b;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    $display("mid-frame frame_start: scene=%0h", bus.scene_bus);
    chk("scene_hold", bus.scene_bus, scene_a);
    chk("busy_hold",  bus.busy,      1);

    // All four lanes complete in the same cycle.
    for (int i = 0; i < NL; i++) bus.lane_dout[i*CW +: CW] = pix_color(7'(i), 6'd0);
    bus.lane_done = '1;
    tick();
    bus.lane_done = '0;
    chk("wr_registered", bus.wr_en, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("drain cycle D+%0d: wr_en=%b col=%0d row=%0d dout=%0h lane_start=%b", k + 1, bus.wr_en, bus.col_addr, bus.row_addr, bus.dout, bus.lane_start);
      chk("sim_wr_en", bus.wr_en, (k < 4) ? 1 : 0);
      if (k < 4) begin
        chk("sim_col",  bus.col_addr, k);
        chk("sim_row",  bus.row_addr, 0);
        chk("sim_dout", bus.dout,     pix_color(7'(k), 6'd0));
      end
      if (k == 1) begin
        chk("redisp_ls",  bus.lane_start, 1);
        chk("redisp_col", bus.lane_col,   4);
      end
    end

    // Reset in the middle of the frame.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    $display("mid-frame reset: busy=%b wr_en=%b lane_start=%b", bus.busy, bus.wr_en, bus.lane_start);
    chk("mrst_busy",       bus.busy,       0);
    chk("mrst_lane_start", bus.lane_start, 0);
    chk("mrst_lane_col",   bus.lane_col,   0);
    chk("mrst_wr_en",      bus.wr_en,      0);
    chk("mrst_col_addr",   bus.col_addr,   0);
    chk("mrst_dout",       bus.dout,       0);
    chk("mrst_scene",      bus.scene_bus,  0);
    bus.lane_done = '1;
    tick();
    bus.lane_done = '0;
    wr_seen = 0;
    ls_seen = 0;
    repeat (4) begin
      tick();
      wr_seen += int'(bus.wr_en);
      ls_seen += (bus.lane_start != '0) ? 1 : 0;
    end
    $display("stale lane_done: writes=%0d starts=%0d", wr_seen, ls_seen);
    chk("stale_wr",   wr_seen,  0);
    chk("stale_ls",   ls_seen,  0);
    chk("stale_busy", bus.busy, 0);

    // Full frame with the fixed-latency lane model.
    for (int i = 0; i < NL; i++) cnt[i] = 0;
    sb.delete();
    bus.in_bus = scene_c;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    disp_n = 0; wr_n = 0; done_n = 0; done_cyc = 0; cyc = 0; extra = 0;
    exp_c = '0; exp_r = '0;
    while (cyc < BUDGET) begin
      tick();
      cyc++;
      bus.lane_done = '0;
      for (int i = 0; i < NL; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            bus.lane_done[i] = 1'b1;
            bus.lane_dout[i*CW +: CW] = pix_color(tc[i], tr[i]);
            sb.push_back('{c: tc[i], r: tr[i], color: pix_color(tc[i], tr[i])});
          end
        end
      end
      if (bus.lane_start != '0) begin
        if (disp_n < NPIX) begin
          chk("ff_onehot", $onehot(bus.lane_start), 1);
          chk("ff_raster", {bus.lane_col, bus.lane_row}, {exp_c, exp_r});
          if (exp_c == 7'd127) begin
            $display("raster wrap: dispatched (%0d,%0d)", bus.lane_col, bus.lane_row);
            exp_r = exp_r + 6'd1;
          end
          exp_c = exp_c + 7'd1;
          li = 0;
          for (int i = 0; i < NL; i++) if (bus.lane_start[i]) li = i;
          cnt[li] = LAT;
          tc[li]  = bus.lane_col;
          tr[li]  = bus.lane_row;
          disp_n++;
        end else begin
          extra++;
        end
      end
      if (bus.wr_en) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (sb[k].c == bus.col_addr && sb[k].r == bus.row_addr) idx = k;
        chk("ff_found", (idx >= 0) ? 1 : 0, 1);
        if (idx >= 0) begin
          chk("ff_color", bus.dout, sb[idx].color);
          sb.delete(idx);
        end
        wr_n++;
      end
      if (bus.frame_done) begin
        done_n++;
        done_cyc = cyc;
        $display("frame_done at cycle %0d: writes=%0d", cyc, wr_n);
        chk("ff_busy_at_done", bus.busy, 1);
      end
      if (done_n > 0 && cyc == done_cyc + 1) begin
        chk("ff_busy_fall", bus.busy, 0);
        break;
      end
    end
    if (done_n == 0) chk("ff_timeout", done_n, 1);
    repeat (5) begin
      tick();
      done_n += int'(bus.frame_done);
      wr_n   += int'(bus.wr_en);
    end
    $display("frame summary: dispatches=%0d writes=%0d frame_done=%0d extra_starts=%0d", disp_n, wr_n, done_n, extra);
    chk("ff_done_count",  done_n,    1);
    chk("ff_writes",      wr_n,      NPIX);
    chk("ff_dispatches",  disp_n,    NPIX);
    chk("ff_extra_start", extra,     0);
    chk("ff_sb_empty",    sb.size(), 0);
`ifdef TRACER_SCHED_PERF_EN
    chk("perf_cycles", bus.frame_cycles, done_cyc + 1);
`else
    chk("perf_off", bus.frame_cycles, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tracer_scheduler.md
# tracer_scheduler

Frame-level scheduler that shares a pool of per-pixel ray-tracer lanes across one 128x64 frame. It latches the 128-bit scene descriptor at frame start and dispatches pixel coordinates to idle lanes in raster order. It collects each lane's 12-bit colour and serialises results onto a single framebuffer write port, tagged with the originating pixel address. It sits between the display/frame controller and the replicated tracer instances.

## Interface

- NUM_LANES, 4, number of tracer lanes (1..8)
- COLOR_W, 12, colour width per lane result
- tracer_clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle request to render a frame
- in_bus  in  128  scene descriptor, sampled on accepted frame_start
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse, last pixel written
- scene_bus  out  128  latched descriptor, broadcast to all lanes
- lane_start  out  NUM_LANES  one-hot, one-cycle start pulse to a lane
- lane_col  out  7  pixel column, valid with lane_start
- lane_row  out  6  pixel row, valid with lane_start
- lane_done  in  NUM_LANES  per-lane one-cycle completion pulse
- lane_dout  in  NUM_LANES*COLOR_W  lane i colour in bits [i*COLOR_W +: COLOR_W], valid with lane_done[i]
- wr_en  out  1  framebuffer write strobe
- col_addr  out  7  write column
- row_addr  out  6  write row
- dout  out  COLOR_W  write colour
- frame_cycles  out  24  cycle count of the last frame (see Configuration)

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE: frame_start=1 → latch in_bus into scene_bus, clear issue counter to (col 0, row 0), go to RUN. frame_start is ignored in every other state. In-flight in_bus changes never affect scene_bus.
- Per-lane state: FREE, BUSY (tag holds col/row), PEND (result held, awaiting write).
- RUN dispatch: at most one dispatch per cycle, to the lowest-index FREE lane.
  - Dispatch asserts lane_start[i] and drives lane_col/lane_row = counter.
  - The lane goes BUSY with that tag.
  - The counter increments col; col 127 wraps to 0 and increments row.
- After dispatching (127,63), go to DRAIN.
- lane_done[i] with lane i BUSY → capture lane_dout slice, lane i goes PEND. lane_done on a FREE or PEND lane is ignored.
- Write arbitration: each cycle, one PEND lane is chosen round-robin, starting after the last-written lane; lane 0 is first after reset.
  - The chosen lane drives wr_en=1, col_addr/row_addr = its tag, dout = its held colour.
  - The lane goes FREE at the end of that cycle.
- DRAIN: when all lanes are FREE → DONE.
- DONE: frame_done=1 for one cycle → IDLE.
- busy=1 from the cycle after an accepted frame_start through the frame_done cycle inclusive.
- Reset (rst=0 at an edge):
  - All outputs go to 0, scene_bus goes to 0, all lanes go FREE, round-robin pointer goes to lane 0, state goes to IDLE.
  - This applies mid-frame too; in-flight results are dropped, and later lane_done pulses are ignored.
- Every pixel is written exactly once per frame. Write order is not raster order.

## Timing

- frame_start sampled at edge T → first lane_start in cycle T+1 (col 0, row 0). Lane k (all FREE) starts in cycle T+1+k.
- lane_done[i] sampled at edge D → earliest wr_en for that lane is cycle D+1, which is registered.
- A lane written in cycle W is dispatchable again in cycle W+1.
- The write port sustains 1 write/cycle. N lanes completing simultaneously drain in N consecutive cycles.
- frame_done is asserted the cycle after the last wr_en, as the DRAIN→DONE transition.
- All outputs are registered; there is no combinational path from lane_done to wr_en.

## Configuration

- TRACER_SCHED_PERF_EN defined:
  - frame_cycles clears on an accepted frame_start and increments every cycle while busy, saturating at 2^24-1.
  - It holds its value after frame_done until the next frame_start.
- TRACER_SCHED_PERF_EN undefined: frame_cycles is constant 0 and the counter is not synthesised.

## Test plan

- NUM_LANES=4, lane model fixed latency 5, full frame:
  - exactly 8192 wr_en, each (col,row) pair once
  - one frame_done
  - busy falls in the frame_done+1 cycle
- frame_start at T, all lanes FREE → lane_start=0001 (0,0) at T+1, 0010 (1,0) at T+2, 0100 (2,0) at T+3, 1000 (3,0) at T+4.
- All four lanes raise lane_done in the same cycle D:
  - wr_en in D+1..D+4, from lanes 0,1,2,3 with matching tags/colours
  - lane 0 re-dispatched at D+2
- Raster wrap: dispatch of (127,0) is followed by (0,1); after (127,63) no further lane_start, and the state enters DRAIN.
- rst=0 for one cycle mid-frame:
  - next cycle all outputs are 0, busy=0
  - stale lane_done pulses produce no wr_en
  - a new frame_start restarts at (0,0)
- frame_start and a new in_bus value mid-frame → ignored, scene_bus unchanged. With TRACER_SCHED_PERF_EN, a latency-1 single-lane frame reports frame_cycles ≥ 16384 and holds it.
